btb_resolve_unit: RTL and testbench

- Consumer end of the branch-prediction interface.
- Records each fetch-time prediction (pc, predicted target from the BTB) in an in-order queue.
- Retires entries when the EX stage resolves the control-transfer instruction.
- Produces BTB update writes, front-end redirect and pipeline flush, plus misprediction statistics.

---
 rtl/btb_resolve_unit_pkg.sv | 29 ++
 rtl/btb_resolve_unit_pred_fifo.sv | 64 ++++++
 rtl/btb_resolve_unit.sv | 177 +++++++++++++++++
 tb/tb_btb_resolve_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_resolve_unit_pkg.sv
// Shared types and constants for the branch-resolution slice.
package btb_resolve_unit_pkg;

  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] NO_PRED = 64'd0;

  // One in-flight prediction: fetched pc and what the BTB predicted for it.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
  } pred_entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } resolve_state_e;

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_resolve_unit_pred_fifo.sv
// In-order prediction queue: circular buffer with wrap-bit pointers,
// synchronous clear and a combinational head read port.
module pred_fifo
  import btb_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t wr_data,
  output pred_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t       mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];
  // A write into a full queue is fine when the head leaves the same cycle.
  assign push_ok_s = push && (!full || pop);
  assign pop_ok_s  = pop && !empty;

  // Pointer update; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{pc: 64'd0, pred_pc: 64'd0};
      end
    end else if (!clear && push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/btb_resolve_unit.sv
// Consumer end of the branch-prediction interface: queues fetch-time
// predictions, checks them against EX resolution, emits BTB updates,
// redirect/flush and misprediction statistics.
module btb_resolve_unit
  import btb_resolve_unit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [PC_W-1:0] fetch_pred_pc,
  output logic            queue_full,
  input  logic            resolve_valid,
  input  logic            resolve_cti,
  input  logic            resolve_jump,
  input  logic            resolve_taken,
  input  logic [PC_W-1:0] resolve_target,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic [PC_W-1:0] upd_target,
  output logic            upd_taken,
  output logic            upd_jumped,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     mispredict_count,
  output logic [31:0]     resolve_count,
  output logic            protocol_err
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  resolve_state_e   state_r;
  logic [FCW-1:0]   flush_cnt_r;
  logic             flush_r;
  logic             upd_valid_r;
  logic [PC_W-1:0]  upd_pc_r;
  logic [PC_W-1:0]  upd_target_r;
  logic             upd_taken_r;
  logic             upd_jumped_r;
  logic             redirect_valid_r;
  logic [PC_W-1:0]  redirect_pc_r;
  logic [31:0]      mispredict_count_r;
  logic [31:0]      resolve_count_r;
  logic             protocol_err_r;

  pred_entry_t      head_s;
  pred_entry_t      wr_entry_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             run_s;
  logic             push_s;
  logic             pop_s;
  logic             taken_eff_s;
  logic             correct_s;
  logic             mispredict_s;
  logic             upd_s;
  logic             is_cti_s;
  logic [PC_W-1:0]  actual_next_s;

  assign wr_entry_s = '{pc: fetch_pc, pred_pc: fetch_pred_pc};

  pred_fifo #(
    .DEPTH(DEPTH)
  ) u_pred_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .clear   (mispredict_s),
    .wr_data (wr_entry_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Compare the queue head against the EX outcome and decide queue actions.
  always_comb begin
    run_s         = (state_r == ST_RUN);
    pop_s         = resolve_valid && run_s && !fifo_empty_s;
    taken_eff_s   = resolve_jump | (resolve_cti & resolve_taken);
    is_cti_s      = resolve_cti | resolve_jump;
    actual_next_s = head_s.pc + PC_W'(INSTR_BYTES);
    correct_s     = (head_s.pred_pc == NO_PRED);
    if (taken_eff_s) begin
      actual_next_s = resolve_target;
      correct_s     = (head_s.pred_pc == resolve_target);
    end else begin
      actual_next_s = head_s.pc + PC_W'(INSTR_BYTES);
      correct_s     = (head_s.pred_pc == NO_PRED);
    end
    mispredict_s  = pop_s && !correct_s;
    // Taken CTIs train the BTB; a prediction on a fall-through is stale.
    upd_s         = pop_s && (taken_eff_s || (head_s.pred_pc != NO_PRED));
    // A mispredict squashes everything younger, including this cycle's fetch.
    push_s        = fetch_valid && run_s && !mispredict_s;
  end

  // Registered outputs, statistics and the RUN/FLUSH sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_RUN;
      flush_cnt_r        <= {FCW{1'b0}};
      flush_r            <= 1'b0;
      upd_valid_r        <= 1'b0;
      upd_pc_r           <= 64'd0;
      upd_target_r       <= 64'd0;
      upd_taken_r        <= 1'b0;
      upd_jumped_r       <= 1'b0;
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= 64'd0;
      mispredict_count_r <= 32'd0;
      resolve_count_r    <= 32'd0;
      protocol_err_r     <= 1'b0;
    end else begin
      upd_valid_r      <= upd_s;
      redirect_valid_r <= mispredict_s;
      if (upd_s) begin
        upd_pc_r     <= head_s.pc;
        upd_target_r <= taken_eff_s ? resolve_target : NO_PRED;
        upd_taken_r  <= taken_eff_s & ~resolve_jump;
        upd_jumped_r <= taken_eff_s & resolve_jump;
      end
      if (mispredict_s) begin
        redirect_pc_r      <= actual_next_s;
        mispredict_count_r <= sat_inc32(mispredict_count_r);
      end
      if (pop_s && is_cti_s) begin
        resolve_count_r <= sat_inc32(resolve_count_r);
      end
      if (resolve_valid && run_s && fifo_empty_s) begin
        protocol_err_r <= 1'b1;
      end
      case (state_r)
        ST_RUN: begin
          if (mispredict_s) begin
            state_r     <= ST_FLUSH;
            flush_r     <= 1'b1;
            flush_cnt_r <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == {FCW{1'b0}}) begin
            state_r <= ST_RUN;
            flush_r <= 1'b0;
          end else begin
            flush_cnt_r <= flush_cnt_r - {{(FCW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= ST_RUN;
          flush_r     <= 1'b0;
          flush_cnt_r <= {FCW{1'b0}};
        end
      endcase
    end
  end

  assign queue_full       = fifo_full_s && (state_r == ST_RUN);
  assign upd_valid        = upd_valid_r;
  assign upd_pc           = upd_pc_r;
  assign upd_target       = upd_target_r;
  assign upd_taken        = upd_taken_r;
  assign upd_jumped       = upd_jumped_r;
  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign flush            = flush_r;
  assign mispredict_count = mispredict_count_r;
  assign resolve_count    = resolve_count_r;
  assign protocol_err     = protocol_err_r;

endmodule

// File: tb/tb_btb_resolve_unit.sv
// Directed bench for btb_resolve_unit with a queue-based reference model.
module tb_btb_resolve_unit;

  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int IB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [63:0] fetch_pred_pc;
  logic        queue_full;
  logic        resolve_valid;
  logic        resolve_cti;
  logic        resolve_jump;
  logic        resolve_taken;
  logic [63:0] resolve_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic        upd_jumped;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [31:0] mispredict_count;
  logic [31:0] resolve_count;
  logic        protocol_err;

  btb_resolve_unit #(
    .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .INSTR_BYTES(IB)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred_pc(fetch_pred_pc),
    .queue_full(queue_full),
    .resolve_valid(resolve_valid), .resolve_cti(resolve_cti), .resolve_jump(resolve_jump),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_jumped(upd_jumped),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .mispredict_count(mispredict_count),
    .resolve_count(resolve_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [63:0] m_pc[$];
  logic [63:0] m_pred[$];
  int          m_flush_left = 0;
  logic        e_upd_valid = 1'b0, e_upd_taken = 1'b0, e_upd_jumped = 1'b0;
  logic [63:0] e_upd_pc = 64'd0, e_upd_target = 64'd0;
  logic        e_redirect_valid = 1'b0;
  logic [63:0] e_redirect_pc = 64'd0;
  logic        e_flush = 1'b0, e_full = 1'b0, e_perr = 1'b0;
  logic [31:0] e_mis = 32'd0, e_res = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    logic        taken, ok, mis, do_pop, was_full;
    logic [63:0] hpc, hpred, nxt;
    e_upd_valid      = 1'b0;
    e_redirect_valid = 1'b0;
    if (rst) begin
      m_pc.delete(); m_pred.delete();
      m_flush_left = 0;
      e_mis = 32'd0; e_res = 32'd0; e_perr = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      was_full = (m_pc.size() == DEPTH);
      do_pop   = resolve_valid && (m_pc.size() > 0);
      mis      = 1'b0;
      if (resolve_valid && m_pc.size() == 0) e_perr = 1'b1;
      if (do_pop) begin
        hpc   = m_pc.pop_front();
        hpred = m_pred.pop_front();
        taken = resolve_jump || (resolve_cti && resolve_taken);
        nxt   = taken ? resolve_target : hpc + 64'(IB);
        ok    = taken ? (hpred == resolve_target) : (hpred == 64'd0);
        if (resolve_cti || resolve_jump)
          e_res = (e_res == 32'hFFFF_FFFF) ? e_res : e_res + 32'd1;
        if (taken) begin
          e_upd_valid = 1'b1; e_upd_pc = hpc; e_upd_target = resolve_target;
          e_upd_taken = !resolve_jump; e_upd_jumped = resolve_jump;
        end else if (hpred != 64'd0) begin
          e_upd_valid = 1'b1; e_upd_pc = hpc; e_upd_target = 64'd0;
          e_upd_taken = 1'b0; e_upd_jumped = 1'b0;
        end
        if (!ok) begin
          mis = 1'b1;
          e_redirect_valid = 1'b1; e_redirect_pc = nxt;
          e_mis = (e_mis == 32'hFFFF_FFFF) ? e_mis : e_mis + 32'd1;
          m_pc.delete(); m_pred.delete();
          m_flush_left = FC;
        end
      end
      if (fetch_valid && !mis && (!was_full || do_pop)) begin
        m_pc.push_back(fetch_pc);
        m_pred.push_back(fetch_pred_pc);
      end
    end
    e_flush = (m_flush_left > 0);
    e_full  = (m_pc.size() == DEPTH) && (m_flush_left == 0);
  endtask

  task automatic compare_all();
    chk("upd_valid", upd_valid, e_upd_valid);
    if (e_upd_valid) begin
      chk("upd_pc", upd_pc, e_upd_pc);
      chk("upd_target", upd_target, e_upd_target);
      chk("upd_taken", upd_taken, e_upd_taken);
      chk("upd_jumped", upd_jumped, e_upd_jumped);
    end
    chk("redirect_valid", redirect_valid, e_redirect_valid);
    if (e_redirect_valid) chk("redirect_pc", redirect_pc, e_redirect_pc);
    chk("flush", flush, e_flush);
    chk("queue_full", queue_full, e_full);
    chk("mispredict_count", mispredict_count, e_mis);
    chk("resolve_count", resolve_count, e_res);
    chk("protocol_err", protocol_err, e_perr);
  endtask

  task automatic drive(input logic fv, input logic [63:0] fpc, input logic [63:0] fpred,
                       input logic rv, input logic cti, input logic jmp, input logic tkn,
                       input logic [63:0] tgt);
    fetch_valid = fv; fetch_pc = fpc; fetch_pred_pc = fpred;
    resolve_valid = rv; resolve_cti = cti; resolve_jump = jmp;
    resolve_taken = tkn; resolve_target = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] pred);
    drive(1'b1, pc, pred, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic resolve(input logic cti, input logic jmp, input logic tkn, input logic [63:0] tgt);
    drive(1'b0, 64'd0, 64'd0, 1'b1, cti, jmp, tkn, tgt);
  endtask

  initial begin
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    chk("pin_reset_full", queue_full, 1'b0);
    chk("pin_reset_flush", flush, 1'b0);
    chk("pin_reset_mis", mispredict_count, 32'd0);
    chk("pin_reset_perr", protocol_err, 1'b0);

    // Correct taken branch.
    push(64'h100, 64'h200);
    resolve(1'b1, 1'b0, 1'b1, 64'h200);
    chk("pin_tk_upd_valid", upd_valid, 1'b1);
    chk("pin_tk_upd_target", upd_target, 64'h200);
    chk("pin_tk_upd_taken", upd_taken, 1'b1);
    chk("pin_tk_redirect", redirect_valid, 1'b0);
    chk("pin_tk_res_cnt", resolve_count, 32'd1);

    // Non-CTI without prediction: no update, no count.
    push(64'h300, 64'h0);
    resolve(1'b0, 1'b0, 1'b0, 64'h0);
    chk("pin_noncti_upd", upd_valid, 1'b0);

    // Not-taken mispredict, then a flush window that ignores inputs.
    push(64'h100, 64'h200);
    resolve(1'b1, 1'b0, 1'b0, 64'h0);
    chk("pin_nt_upd_target", upd_target, 64'h0);
    chk("pin_nt_redirect_pc", redirect_pc, 64'h104);
    chk("pin_nt_flush", flush, 1'b1);
    chk("pin_nt_mis", mispredict_count, 32'd1);
    drive(1'b1, 64'h900, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h999);
    chk("pin_fw_flush1", flush, 1'b1);
    chk("pin_fw_upd", upd_valid, 1'b0);
    drive(1'b1, 64'h904, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h999);
    chk("pin_fw_flush2", flush, 1'b0);
    chk("pin_fw_res_cnt", resolve_count, 32'd2);

    // Jump with no prediction.
    push(64'h40, 64'h0);
    resolve(1'b0, 1'b1, 1'b0, 64'h80);
    chk("pin_jmp_jumped", upd_jumped, 1'b1);
    chk("pin_jmp_target", upd_target, 64'h80);
    chk("pin_jmp_redirect", redirect_pc, 64'h80);
    idle(); idle();

    // Fill the queue, drop an overflow push, then push+pop while full.
    for (int i = 0; i < DEPTH; i++) push(64'h1000 + 64'(4 * i), 64'h2000 + 64'(16 * i));
    chk("pin_full", queue_full, 1'b1);
    push(64'h5000, 64'h6000);
    chk("pin_full_drop", queue_full, 1'b1);
    drive(1'b1, 64'h1010, 64'h2040, 1'b1, 1'b1, 1'b0, 1'b1, 64'h2000);
    chk("pin_full_pp", queue_full, 1'b1);
    for (int i = 1; i <= DEPTH; i++) resolve(1'b1, 1'b0, 1'b1, 64'h2000 + 64'(16 * i));
    chk("pin_order_mis", mispredict_count, 32'd2);
    chk("pin_order_res", resolve_count, 32'd8);

    // Mispredict with a same-cycle push: the push must be discarded.
    push(64'h500, 64'h600);
    drive(1'b1, 64'h700, 64'h710, 1'b1, 1'b1, 1'b0, 1'b1, 64'h900);
    idle(); idle();

    // Resolve with an empty queue sets a sticky error.
    resolve(1'b1, 1'b0, 1'b1, 64'h123);
    chk("pin_perr", protocol_err, 1'b1);
    idle();
    chk("pin_perr_sticky", protocol_err, 1'b1);

    // Fall-through wrap at the top of the address space, then reset mid-flush.
    push(64'hFFFF_FFFF_FFFF_FFFC, 64'h10);
    resolve(1'b1, 1'b0, 1'b0, 64'h0);
    chk("pin_wrap_redirect", redirect_pc, 64'h0);
    idle();
    chk("pin_wrap_flush", flush, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("pin_rst_flush", flush, 1'b0);
    chk("pin_rst_perr", protocol_err, 1'b0);
    chk("pin_rst_mis", mispredict_count, 32'd0);

    // Normal operation resumes after reset.
    push(64'h2000, 64'h3000);
    resolve(1'b1, 1'b0, 1'b1, 64'h3000);
    chk("pin_post_res", resolve_count, 32'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
